mac_result_streamer: RTL and testbench

- Consumer end of the MAC datapath. Takes one snapshot of a fully flattened MAC output matrix (ROWS x COLS, column-major packed, DATA_WIDTH per element) on a valid/ready handshake.
- Streams the snapshot out row-major, LANES elements per beat, over a valid/ready interface with row/column tags and row/matrix-end flags.
- Sits between the MAC/matmul stage and downstream ops or the memory writer, converting the wide parallel bus into a narrow stream.

---
 rtl/mac_result_streamer.sv | 135 +++++++++++++
 tb/tb_mac_result_streamer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_streamer.sv
// Captures one flattened ROWS x COLS MAC result matrix (column-major) and
// replays it row-major as a LANES-wide valid/ready stream with row/col tags.
module mac_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 128,
    parameter int COLS       = 3072,
    parameter int LANES      = 4,
    parameter int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                             clk_p,
    input  logic                             rst_p,
    input  logic [DATA_WIDTH*ROWS*COLS-1:0]  mac_matrix,
    input  logic                             mac_valid,
    output logic                             mac_ready,
    input  logic                             flush,
    output logic [DATA_WIDTH*LANES-1:0]      out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ROW_W-1:0]                 out_row,
    output logic [COL_W-1:0]                 out_col,
    output logic                             out_last_row,
    output logic                             out_last,
    output logic                             busy
);

    if (COLS % LANES != 0) begin : g_bad_lanes
        $error("mac_result_streamer: COLS must be a multiple of LANES");
    end

    // Handshakes: a transfer happens on a cycle where valid & ready are both
    // high at the rising edge. Once out_valid is raised, out_data and all tags
    // stay frozen until the beat is taken (or flush/reset drops the stream).
    // mac_valid may wait on mac_ready; a matrix is taken only in IDLE.

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t                          state, state_next;
    logic [ROW_W-1:0]                row, row_next;
    logic [COL_W-1:0]                col, col_next;
    logic                            capture;
    logic [DATA_WIDTH*ROWS*COLS-1:0] snapshot;
    logic [DATA_WIDTH*LANES-1:0]     lane_data;
    logic                            col_last;
    logic                            row_last;
    logic                            beat_taken;

    assign col_last   = (col == COL_W'(COLS - LANES));
    assign row_last   = (row == ROW_W'(ROWS - 1));
    assign beat_taken = (state == STREAM) && out_ready;

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
            col   <= col_next;
        end
    end

    // Snapshot needs no reset: nothing reads it until a capture has happened.
    always_ff @(posedge clk_p) begin
        if (!rst_p && capture) begin
            snapshot <= mac_matrix;
        end
    end

    always_comb begin
        state_next = state;
        row_next   = row;
        col_next   = col;
        capture    = 1'b0;
        if (flush) begin
            // A beat handshaking in this cycle is considered consumed.
            state_next = IDLE;
            row_next   = '0;
            col_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mac_valid) begin
                        capture    = 1'b1;
                        state_next = STREAM;
                        row_next   = '0;
                        col_next   = '0;
                    end
                end
                STREAM: begin
                    if (beat_taken) begin
                        if (col_last && row_last) begin
                            state_next = IDLE;
                            row_next   = '0;
                            col_next   = '0;
                        end else if (col_last) begin
                            col_next = '0;
                            row_next = row + ROW_W'(1);
                        end else begin
                            col_next = col + COL_W'(LANES);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    row_next   = '0;
                    col_next   = '0;
                end
            endcase
        end
    end

    // Element (r,c) sits at flat index c*ROWS + r in the column-major snapshot.
    always_comb begin
        lane_data = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_data[k*DATA_WIDTH +: DATA_WIDTH] =
                snapshot[((int'(col) + k) * ROWS + int'(row)) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign mac_ready    = (state == IDLE);
    assign out_valid    = (state == STREAM);
    assign busy         = (state == STREAM);
    assign out_data     = out_valid ? lane_data : '0;
    assign out_row      = row;
    assign out_col      = col;
    assign out_last_row = out_valid && col_last;
    assign out_last     = out_valid && col_last && row_last;

endmodule

// File: tb/tb_mac_result_streamer.sv
// Directed bench for mac_result_streamer with a 2x4 matrix streamed 2 lanes
// per beat; element (r,c) holds r*16+c plus a per-matrix offset.
module tb_mac_result_streamer;

    localparam int DW    = 8;
    localparam int ROWS  = 2;
    localparam int COLS  = 4;
    localparam int LANES = 2;
    localparam int ROW_W = 1;
    localparam int COL_W = 2;

    logic                      clk_p = 1'b0;
    logic                      rst_p;
    logic [DW*ROWS*COLS-1:0]   mac_matrix;
    logic                      mac_valid;
    logic                      mac_ready;
    logic                      flush;
    logic [DW*LANES-1:0]       out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [ROW_W-1:0]          out_row;
    logic [COL_W-1:0]          out_col;
    logic                      out_last_row;
    logic                      out_last;
    logic                      busy;

    int n_total = 0;
    int n_pass  = 0;

    mac_result_streamer #(
        .DATA_WIDTH(DW),
        .ROWS      (ROWS),
        .COLS      (COLS),
        .LANES     (LANES)
    ) dut (
        .clk_p       (clk_p),
        .rst_p       (rst_p),
        .mac_matrix  (mac_matrix),
        .mac_valid   (mac_valid),
        .mac_ready   (mac_ready),
        .flush       (flush),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row     (out_row),
        .out_col     (out_col),
        .out_last_row(out_last_row),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk_p = ~clk_p;

    function automatic logic [DW*ROWS*COLS-1:0] make_matrix(input logic [7:0] ofs);
        logic [DW*ROWS*COLS-1:0] m;
        m = '0;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                m[(c*ROWS + r)*DW +: DW] = 8'(r*16 + c) + ofs;
            end
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk_p);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_beat(input string tag, input logic [15:0] data, input int row,
                              input int col, input logic lr, input logic last);
        check({tag, ".valid"},    32'(out_valid),    32'd1);
        check({tag, ".data"},     32'(out_data),     32'(data));
        check({tag, ".row"},      32'(out_row),      32'(row));
        check({tag, ".col"},      32'(out_col),      32'(col));
        check({tag, ".last_row"}, 32'(out_last_row), 32'(lr));
        check({tag, ".last"},     32'(out_last),     32'(last));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"},     32'(out_valid), 32'd0);
        check({tag, ".mac_ready"}, 32'(mac_ready), 32'd1);
        check({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        rst_p      = 1'b1;
        mac_matrix = '0;
        mac_valid  = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;

        // Reset state
        step();
        step();
        rst_p = 1'b0;
        check_idle("rst");
        check("rst.data",     32'(out_data),     32'd0);
        check("rst.row",      32'(out_row),      32'd0);
        check("rst.col",      32'(out_col),      32'd0);
        check("rst.last_row", 32'(out_last_row), 32'd0);
        check("rst.last",     32'(out_last),     32'd0);

        // Basic stream
        mac_matrix = make_matrix(8'h00);
        mac_valid  = 1'b1;
        out_ready  = 1'b1;
        step();
        mac_valid = 1'b0;
        check_beat("basic.b1", 16'h0100, 0, 0, 1'b0, 1'b0);
        check("basic.busy",      32'(busy),      32'd1);
        check("basic.mac_ready", 32'(mac_ready), 32'd0);
        step();
        check_beat("basic.b2", 16'h0302, 0, 2, 1'b1, 1'b0);
        step();
        check_beat("basic.b3", 16'h1110, 1, 0, 1'b0, 1'b0);
        step();
        check_beat("basic.b4", 16'h1312, 1, 2, 1'b1, 1'b1);
        step();
        check_idle("basic.end");

        // Backpressure on beat 2
        mac_valid = 1'b1;
        step();
        mac_valid = 1'b0;
        check_beat("bp.b1", 16'h0100, 0, 0, 1'b0, 1'b0);
        step();
        check_beat("bp.b2", 16'h0302, 0, 2, 1'b1, 1'b0);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_beat("bp.stall", 16'h0302, 0, 2, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        step();
        check_beat("bp.b3", 16'h1110, 1, 0, 1'b0, 1'b0);
        step();
        check_beat("bp.b4", 16'h1312, 1, 2, 1'b1, 1'b1);
        step();
        check_idle("bp.end");

        // Back-to-back matrices; upstream changes mid-stream must not leak in
        mac_matrix = make_matrix(8'h00);
        mac_valid  = 1'b1;
        step();
        mac_matrix = make_matrix(8'h40);
        check_beat("b2b.m0b1", 16'h0100, 0, 0, 1'b0, 1'b0);
        step();
        check_beat("b2b.m0b2", 16'h0302, 0, 2, 1'b1, 1'b0);
        step();
        check_beat("b2b.m0b3", 16'h1110, 1, 0, 1'b0, 1'b0);
        step();
        check_beat("b2b.m0b4", 16'h1312, 1, 2, 1'b1, 1'b1);
        step();
        check_idle("b2b.bubble");
        step();
        mac_valid = 1'b0;
        check_beat("b2b.m1b1", 16'h4140, 0, 0, 1'b0, 1'b0);
        step();
        check_beat("b2b.m1b2", 16'h4342, 0, 2, 1'b1, 1'b0);
        step();
        check_beat("b2b.m1b3", 16'h5150, 1, 0, 1'b0, 1'b0);
        step();
        check_beat("b2b.m1b4", 16'h5352, 1, 2, 1'b1, 1'b1);
        step();
        check_idle("b2b.end");

        // Flush while beat 2 handshakes
        mac_matrix = make_matrix(8'h00);
        mac_valid  = 1'b1;
        step();
        mac_valid = 1'b0;
        check_beat("fl.b1", 16'h0100, 0, 0, 1'b0, 1'b0);
        step();
        check_beat("fl.b2", 16'h0302, 0, 2, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_idle("fl.after");
        check("fl.row", 32'(out_row), 32'd0);
        check("fl.col", 32'(out_col), 32'd0);
        step();
        check_idle("fl.quiet");
        // Flush in IDLE blocks capture
        mac_matrix = make_matrix(8'h20);
        mac_valid  = 1'b1;
        flush      = 1'b1;
        step();
        flush = 1'b0;
        check_idle("fl.idle_block");
        step();
        mac_valid = 1'b0;
        check_beat("fl.re_b1", 16'h2120, 0, 0, 1'b0, 1'b0);
        step();
        check_beat("fl.re_b2", 16'h2322, 0, 2, 1'b1, 1'b0);
        step();
        check_beat("fl.re_b3", 16'h3130, 1, 0, 1'b0, 1'b0);
        step();
        check_beat("fl.re_b4", 16'h3332, 1, 2, 1'b1, 1'b1);
        step();
        check_idle("fl.end");

        // Reset mid-stream with mac_valid still asserted
        mac_matrix = make_matrix(8'h00);
        mac_valid  = 1'b1;
        step();
        check_beat("mr.b1", 16'h0100, 0, 0, 1'b0, 1'b0);
        step();
        step();
        check_beat("mr.b3", 16'h1110, 1, 0, 1'b0, 1'b0);
        rst_p = 1'b1;
        step();
        rst_p     = 1'b0;
        mac_valid = 1'b0;
        check_idle("mr.rst");
        check("mr.data",     32'(out_data),     32'd0);
        check("mr.row",      32'(out_row),      32'd0);
        check("mr.col",      32'(out_col),      32'd0);
        check("mr.last_row", 32'(out_last_row), 32'd0);
        check("mr.last",     32'(out_last),     32'd0);
        step();
        check_idle("mr.no_capture");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
